// File: rtl/csa_drain_pkg.sv
// Shared types and width helpers for the carry-save drain accumulator.
package csa_drain_pkg;

    localparam int unsigned AccWidthDef = 32;

    // Width of each carry-save word produced by the upstream winograd core.
    function automatic int unsigned calc_in_width(input int unsigned in_size_1);
        return ((in_size_1 + 1) * 2) + 6;
    endfunction

    typedef enum logic [0:0] {
        StIdle,
        StAccum
    } state_e;

    typedef struct packed {
        logic                   ovf;
        logic [AccWidthDef-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Register-based first-word-fall-through FIFO; head output holds the last popped word when empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [PtrW:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] hold_q;
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != (PtrW+1)'(DEPTH)) || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            hold_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                hold_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign valid_o = (count_q != '0);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : hold_q;
    assign count_o = count_q;

endmodule

// File: rtl/csa_drain_acc.sv
// Resolves carry-save pairs, accumulates a configurable number of tiles per group,
// and queues each group result with its overflow flag.
module csa_drain_acc
    import csa_drain_pkg::*;
#(
    parameter int unsigned IN_SIZE_1  = 8,
    parameter int unsigned IN_WIDTH   = calc_in_width(IN_SIZE_1),
    parameter int unsigned ACC_WIDTH  = AccWidthDef,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [LEN_WIDTH-1:0] cfg_len_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [IN_WIDTH-1:0]  in_sum_i,
    input  logic [IN_WIDTH-1:0]  in_carry_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [ACC_WIDTH-1:0] out_data_o,
    output logic                 out_ovf_o,
    output logic                 busy_o
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    state_e               state_q;
    logic [LEN_WIDTH-1:0] len_q, cnt_q;
    logic                 s1_valid_q, s1_last_q;
    logic [ACC_WIDTH-1:0] s1_val_q, acc_q;
    logic                 ovf_q;

    logic                 accept, beat_last, push;
    logic [IN_WIDTH-1:0]  resolved;
    logic [LEN_WIDTH-1:0] eff_len, cnt_inc;
    logic [ACC_WIDTH:0]   sum_ext;
    logic [CntW-1:0]      fifo_count;
    logic [ACC_WIDTH:0]   fifo_din, fifo_dout;

    assign resolved = in_sum_i + in_carry_i;
    assign eff_len  = (cfg_len_i == '0) ? LEN_WIDTH'(1) : cfg_len_i;
    assign cnt_inc  = cnt_q + 1'b1;
    assign beat_last = (state_q == StIdle) ? (eff_len == LEN_WIDTH'(1)) : (cnt_inc == len_q);

    // A beat sitting in stage 1 reserves a FIFO slot, so a push can never find the FIFO full.
    assign in_ready_o = ((CntW+1)'(fifo_count) + (CntW+1)'(s1_valid_q)) < (CntW+1)'(FIFO_DEPTH);
    assign accept     = in_valid_i && in_ready_o;
    assign busy_o     = (state_q == StAccum) || s1_valid_q;

    assign sum_ext  = {1'b0, acc_q} + {1'b0, s1_val_q};
    assign push     = s1_valid_q && s1_last_q;
    assign fifo_din = {ovf_q | sum_ext[ACC_WIDTH], sum_ext[ACC_WIDTH-1:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            len_q      <= '0;
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_val_q   <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_val_q  <= ACC_WIDTH'(resolved);
                s1_last_q <= beat_last;
                unique case (state_q)
                    StIdle: begin
                        len_q   <= eff_len;
                        cnt_q   <= LEN_WIDTH'(1);
                        state_q <= beat_last ? StIdle : StAccum;
                    end
                    StAccum: begin
                        cnt_q <= cnt_inc;
                        if (beat_last) begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
            if (s1_valid_q) begin
                if (s1_last_q) begin
                    acc_q <= '0;
                    ovf_q <= 1'b0;
                end else begin
                    acc_q <= sum_ext[ACC_WIDTH-1:0];
                    ovf_q <= ovf_q | sum_ext[ACC_WIDTH];
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH(ACC_WIDTH + 1),
        .DEPTH(FIFO_DEPTH)
    ) u_out_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (push),
        .data_i (fifo_din),
        .pop_i  (out_ready_i),
        .data_o (fifo_dout),
        .valid_o(out_valid_o),
        .count_o(fifo_count)
    );

    assign out_data_o = fifo_dout[ACC_WIDTH-1:0];
    assign out_ovf_o  = fifo_dout[ACC_WIDTH];

endmodule

// File: tb/tb_csa_drain_acc.sv
// Scoreboard bench: a group model pushes expected {ovf, data} per accepted last beat,
// the output monitor pops and compares on every FIFO pop.
module tb_csa_drain_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cfg_len;
    logic        in_valid, in_valid24;
    logic [23:0] in_sum, in_carry;
    logic        out_ready;
    logic        in_ready, out_valid, out_ovf, busy;
    logic [31:0] out_data;
    logic        in_ready24, out_valid24, out_ovf24, busy24;
    logic [23:0] out_data24;

    logic [32:0] sb[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          accepted = 0;

    logic [7:0]  m_len;
    logic [7:0]  m_cnt;
    logic [31:0] m_acc;
    logic        m_ovf;

    always #5 clk = ~clk;

    csa_drain_acc dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cfg_len_i  (cfg_len),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_sum_i   (in_sum),
        .in_carry_i (in_carry),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .out_ovf_o  (out_ovf),
        .busy_o     (busy)
    );

    csa_drain_acc #(.ACC_WIDTH(24)) dut24 (
        .clk_i      (clk),
        .rst_i      (rst),
        .cfg_len_i  (cfg_len),
        .in_valid_i (in_valid24),
        .in_ready_o (in_ready24),
        .in_sum_i   (in_sum),
        .in_carry_i (in_carry),
        .out_valid_o(out_valid24),
        .out_ready_i(1'b1),
        .out_data_o (out_data24),
        .out_ovf_o  (out_ovf24),
        .busy_o     (busy24)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_clear();
        m_cnt = '0;
        m_len = '0;
        m_acc = '0;
        m_ovf = 1'b0;
    endtask

    task automatic model_beat(input logic [23:0] s, input logic [23:0] c);
        logic [23:0] r;
        logic [32:0] t;
        r = s + c;
        t = {1'b0, m_acc} + {9'd0, r};
        m_ovf = m_ovf | t[32];
        m_acc = t[31:0];
        if (m_cnt == 0) begin
            m_len = (cfg_len == 0) ? 8'd1 : cfg_len;
        end
        m_cnt = m_cnt + 1'b1;
        if (m_cnt == m_len) begin
            sb.push_back({m_ovf, m_acc});
            model_clear();
        end
    endtask

    // Called at #1 after a posedge; returns at #1 after the accepting posedge.
    task automatic send(input logic [23:0] s, input logic [23:0] c);
        int waited = 0;
        bit ok = 0;
        in_sum = s;
        in_carry = c;
        in_valid = 1'b1;
        while (!ok && waited < 200) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                accepted++;
                model_beat(s, c);
            end
            @(posedge clk);
            #1;
            waited++;
        end
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        model_clear();
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", {31'd0, out_ovf, out_data}, 64'hdead);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                check("out_data", {32'd0, out_data}, {32'd0, e[31:0]});
                check("out_ovf", {63'd0, out_ovf}, {63'd0, e[32]});
            end
        end
    end

    initial begin
        int w;
        rst = 1'b1;
        cfg_len = 8'd1;
        in_valid = 1'b0;
        in_valid24 = 1'b0;
        in_sum = '0;
        in_carry = '0;
        out_ready = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", {32'd0, out_data}, 64'd0);
        check("rst_out_ovf", {63'd0, out_ovf}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;

        // Single tile and two-cycle latency.
        cfg_len = 8'd1;
        send(24'h000010, 24'h000005);
        @(negedge clk);
        check("lat_cycle1_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        check("lat_cycle2_valid", {63'd0, out_valid}, 64'd1);
        check("lat_cycle2_data", {32'd0, out_data}, 64'h15);
        repeat (3) @(posedge clk);
        #1;

        // Group of four.
        cfg_len = 8'd4;
        for (int i = 0; i < 3; i++) begin
            send(24'd1, 24'd1);
            @(negedge clk);
            check("grp_busy", {63'd0, busy}, 64'd1);
            check("grp_no_out", {63'd0, out_valid}, 64'd0);
            @(posedge clk);
            #1;
        end
        send(24'd1, 24'd1);
        @(negedge clk);
        check("grp_last_busy", {63'd0, busy}, 64'd1);
        @(negedge clk);
        check("grp_done_busy", {63'd0, busy}, 64'd0);
        check("grp_out_valid", {63'd0, out_valid}, 64'd1);
        repeat (3) @(posedge clk);
        #1;

        // Input-width wrap.
        cfg_len = 8'd1;
        send(24'hFFFFFF, 24'h000002);
        repeat (3) @(posedge clk);
        #1;

        // Accumulator wrap on the 24-bit instance.
        check("acc24_ready", {63'd0, in_ready24}, 64'd1);
        cfg_len = 8'd2;
        in_valid24 = 1'b1;
        in_sum = 24'hFFFFFF;
        in_carry = 24'h0;
        @(posedge clk);
        #1;
        in_sum = 24'h000001;
        in_carry = 24'h000001;
        @(posedge clk);
        #1;
        in_valid24 = 1'b0;
        @(negedge clk);
        check("acc24_early", {63'd0, out_valid24}, 64'd0);
        @(negedge clk);
        check("acc24_valid", {63'd0, out_valid24}, 64'd1);
        check("acc24_data", {40'd0, out_data24}, 64'h1);
        check("acc24_ovf", {63'd0, out_ovf24}, 64'd1);
        @(posedge clk);
        #1;
        cfg_len = 8'd1;
        in_valid24 = 1'b1;
        in_sum = 24'd3;
        in_carry = 24'd0;
        @(posedge clk);
        #1;
        in_valid24 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("acc24_next_data", {40'd0, out_data24}, 64'h3);
        check("acc24_next_ovf", {63'd0, out_ovf24}, 64'd0);
        @(posedge clk);
        #1;

        // Backpressure: only FIFO_DEPTH beats get in while the output is stalled.
        out_ready = 1'b0;
        cfg_len = 8'd1;
        accepted = 0;
        fork
            begin
                for (int i = 1; i <= 10; i++) send(24'(i), 24'd0);
            end
            begin
                repeat (8) @(negedge clk);
                check("bp_accepted", 64'(accepted), 64'd4);
                check("bp_in_ready", {63'd0, in_ready}, 64'd0);
                check("bp_out_valid", {63'd0, out_valid}, 64'd1);
                check("bp_head", {32'd0, out_data}, 64'd1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        check("bp_total", 64'(accepted), 64'd10);
        repeat (8) @(posedge clk);
        #1;

        // Reset in the middle of a group.
        cfg_len = 8'd3;
        send(24'd5, 24'd0);
        send(24'd5, 24'd0);
        do_reset();
        @(negedge clk);
        check("mrst_in_ready", {63'd0, in_ready}, 64'd1);
        check("mrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mrst_out_data", {32'd0, out_data}, 64'd0);
        check("mrst_busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
        cfg_len = 8'd1;
        send(24'd7, 24'd0);
        repeat (3) @(posedge clk);
        #1;

        // Config change mid-group is ignored until the next group.
        cfg_len = 8'd2;
        send(24'd1, 24'd0);
        cfg_len = 8'd5;
        send(24'd2, 24'd0);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 1; i <= 4; i++) send(24'(i), 24'd0);
        repeat (3) @(negedge clk);
        check("cfg_no_early_out", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1;
        send(24'd5, 24'd0);

        // Zero length behaves as one.
        cfg_len = 8'd0;
        send(24'd9, 24'd1);

        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(posedge clk);
            w++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/csa_drain_acc.md
Name: csa_drain_acc

Overview:
- Receiving end of the winograd carry-save output pair: consumes the (sum, carry) redundant result stream and resolves it with a carry-propagate add.
- Accumulates a programmable number of tiles per output group.
- Delivers final accumulated words through an output FIFO with valid/ready backpressure.
- Sits between the winograd core's output registers and the result writeback path.

Parameters:
- IN_SIZE_1, 8, operand width used by the upstream core.
- IN_WIDTH, ((IN_SIZE_1+1)*2)+6 (=24), width of each carry-save input word.
- ACC_WIDTH, 32, accumulator and output data width; must be >= IN_WIDTH.
- FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2.
- LEN_WIDTH, 8, width of the group-length configuration.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- cfg_len_i  in  LEN_WIDTH  tiles per group; value 0 is treated as 1.
- in_valid_i  in  1  carry-save pair valid.
- in_ready_o  out  1  block can accept a pair.
- in_sum_i  in  IN_WIDTH  sum vector.
- in_carry_i  in  IN_WIDTH  carry vector, already weight-aligned.
- out_valid_o  out  1  FIFO head valid.
- out_ready_i  in  1  downstream accepts the head.
- out_data_o  out  ACC_WIDTH  accumulated group result.
- out_ovf_o  out  1  ACC_WIDTH wrap occurred within this group (travels with the data).
- busy_o  out  1  group in progress, or a beat in stage 1.

Behaviour:
- Reset: one cycle of rst_i high at a clock edge clears everything: FSM to IDLE, tile counter, accumulator, stage-1 register and FIFO pointers. After reset: in_ready_o=1, out_valid_o=0, out_data_o=0, out_ovf_o=0, busy_o=0. Reset mid-group discards the partial sum and any FIFO contents.
- Handshake: a beat transfers when in_valid_i && in_ready_o at a clock edge. A pop occurs when out_valid_o && out_ready_i.
- Stage 1: on accept, register the resolved value r = (in_sum_i + in_carry_i) mod 2^IN_WIDTH, zero-extended to ACC_WIDTH. Also register the "last" flag.
- Stage 2 (edge after stage 1 is valid): a = acc + r mod 2^ACC_WIDTH. Set ovf_acc |= carry-out of that add.
  - If last: push {ovf, a} into the FIFO, then clear acc and ovf_acc to 0.
  - Otherwise: acc <= a.
- Latency: out_valid_o rises 2 cycles after the accept cycle of a group's last beat, provided the FIFO was empty. The FIFO is first-word-fall-through from registers.
- FSM IDLE: on accept, latch len = max(cfg_len_i, 1) and set cnt=1. If len==1, that beat is last and the FSM stays in IDLE. Otherwise go to ACCUM.
- FSM ACCUM: each accept increments cnt. The beat with cnt==len is last, and the FSM returns to IDLE. cfg_len_i changes during ACCUM are ignored.
- in_ready_o = (fifo_count + s1_valid) < FIFO_DEPTH. This is conservative: a beat in stage 1 reserves a FIFO slot whether or not it is last. It is registered-safe, with no combinational path from out_ready_i.
- Simultaneous push and pop with the FIFO full is legal: count is unchanged and no data is lost. Push into an empty FIFO with a pop in the same cycle is impossible (out_valid_o=0), so there is no bypass.
- busy_o = (state==ACCUM) || s1_valid.
- No X on outputs after reset. out_data_o holds its last value while out_valid_o=0.

Decomposition:
- Package csa_drain_pkg holds the IN_WIDTH/ACC_WIDTH derivation function, the state enum typedef {IDLE, ACCUM}, and the FIFO entry struct {ovf, data}.
- One sub-module, sync_fifo (parameterised width and depth, synchronous active-high reset, count output), instantiated once for the output buffer.

Test Plan:
- Single tile: len=1, sum=0x000010, carry=0x000005, out_ready=1 -> out_valid_o high 2 cycles after accept, out_data_o=0x00000015, out_ovf_o=0.
- Group of 4: len=4, four beats of sum=1, carry=1 -> exactly one output of 0x00000008. No output after beats 1–3, and busy_o stays high until the push.
- Input wrap: len=1, sum=0xFFFFFF, carry=0x000002 -> out_data_o=0x00000001. Accumulator wrap: with ACC_WIDTH=24, len=2 and resolved values 0xFFFFFF and 0x000002 -> out_data_o=0x000001, out_ovf_o=1.
- Backpressure: len=1, out_ready=0, drive 10 back-to-back beats with values 1..10 -> exactly 4 accepted and in_ready_o low afterward. Then raise out_ready=1 -> pops 1,2,3,4 in order, followed by the remaining beats accepted and drained in order.
- Reset mid-group: len=3, two beats of 5, pulse rst_i for 1 cycle, then len=1 with one beat of 7 -> single output 0x00000007, no stale partial sum, no stale FIFO entries.
- Config change mid-group: start with len=2, then change cfg_len_i to 5 after the first beat -> output after the 2nd beat. The following group uses len=5.
